// File: rtl/shift_sequencer.sv
// -----------------------------------------------------------------------------
// shift_sequencer
//
// Multi-cycle shift controller. It uses a shared, purely combinational,
// single-step 32-bit shifter to perform shifts of 0..31 positions. An
// accepted request loads the operand into an accumulator. The accumulator is
// then passed through the shifter once per cycle, `amount` times. The final
// value is returned in a registered result together with a one-cycle done
// pulse.
//
// Handshake: a request is accepted on a rising edge where start=1 and
// ready=1. ready is high only in IDLE. While busy=1, all request inputs are
// ignored, and there is no queuing. done is a single-cycle pulse, and result
// is valid in that same cycle. result holds until the next done.
//
// Ports:
//   clk        in   1   system clock, rising edge
//   reset      in   1   synchronous, active-high reset
//   start      in   1   request strobe, sampled only when ready=1
//   op         in   2   00 SLL, 01 SRL, 10 SRA, 11 ROR
//   amount     in   5   shift distance 0..31
//   operand    in  32   value to shift
//   ready      out  1   high in IDLE
//   busy       out  1   high in SHIFT and DONE
//   done       out  1   one-cycle pulse, result valid
//   result     out 32   registered result
//   sh_in      out 32   to shifter input (always the accumulator)
//   sh_code    out  3   to shifter step code
//   sh_out     in  32   from shifter output (same-cycle combinational path)
//   dbg_state  out  2   current FSM state, for observation only
// -----------------------------------------------------------------------------
module shift_sequencer #(
   parameter logic [2:0] CODE_PASS = 3'b000,
   parameter logic [2:0] CODE_SLL  = 3'b001,
   parameter logic [2:0] CODE_SRL  = 3'b010,
   parameter logic [2:0] CODE_SRA  = 3'b011,
   parameter logic [2:0] CODE_ROR  = 3'b101
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [1:0]  op,
   input  logic [4:0]  amount,
   input  logic [31:0] operand,
   output logic        ready,
   output logic        busy,
   output logic        done,
   output logic [31:0] result,
   output logic [31:0] sh_in,
   output logic [2:0]  sh_code,
   input  logic [31:0] sh_out,
   output logic [1:0]  dbg_state
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   state_t      r_state;
   logic [31:0] r_acc;
   logic [4:0]  r_cnt;
   logic [1:0]  r_op_q;
   logic [31:0] r_result;

   state_t      w_state_nxt;
   logic [2:0]  w_op_code;
   logic [2:0]  w_sh_code;
   logic        w_accept;
   logic        w_step;
   logic        w_load_result;
   logic [31:0] w_result_d;

   // Translate the captured operation into its shifter step code.
   always_comb begin
      w_op_code = CODE_PASS;
      case (r_op_q)
         2'b00:   w_op_code = CODE_SLL;
         2'b01:   w_op_code = CODE_SRL;
         2'b10:   w_op_code = CODE_SRA;
         2'b11:   w_op_code = CODE_ROR;
         default: w_op_code = CODE_PASS;
      endcase
   end

   // Next-state and shifter-code decode.
   always_comb begin
      w_state_nxt = r_state;
      w_sh_code   = CODE_PASS;
      case (r_state)
         ST_IDLE: begin
            if (start) begin
               w_state_nxt = (amount == 5'd0) ? ST_DONE : ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            w_sh_code = w_op_code;
            // cnt is never 0 in SHIFT. The <= guard still leaves SHIFT
            // safely if that state were ever reached.
            if (r_cnt <= 5'd1) begin
               w_state_nxt = ST_DONE;
            end
         end
         ST_DONE: begin
            w_state_nxt = ST_IDLE;
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   assign w_accept = (r_state == ST_IDLE) && start;
   assign w_step   = (r_state == ST_SHIFT);

   // result is written on the edge that enters DONE, so the new value and
   // the done pulse appear in the same cycle. A zero-distance request
   // passes the operand straight through. The last shift step takes the
   // shifter output directly, because the accumulator has not captured it
   // yet.
   assign w_load_result = (w_state_nxt == ST_DONE) && (r_state != ST_DONE);
   assign w_result_d    = w_accept ? operand : sh_out;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state  <= ST_IDLE;
         r_acc    <= 32'd0;
         r_cnt    <= 5'd0;
         r_op_q   <= 2'd0;
         r_result <= 32'd0;
      end else begin
         r_state <= w_state_nxt;
         if (w_accept) begin
            r_acc  <= operand;
            r_op_q <= op;
            r_cnt  <= amount;
         end else if (w_step) begin
            r_acc <= sh_out;
            if (r_cnt != 5'd0) begin
               r_cnt <= r_cnt - 5'd1;
            end
         end
         if (w_load_result) begin
            r_result <= w_result_d;
         end
      end
   end

   assign ready     = (r_state == ST_IDLE);
   assign busy      = (r_state == ST_SHIFT) || (r_state == ST_DONE);
   assign done      = (r_state == ST_DONE);
   assign result    = r_result;
   assign sh_in     = r_acc;
   assign sh_code   = w_sh_code;
   assign dbg_state = r_state;

endmodule

// File: tb/tb_shift_sequencer.sv
module tb_shift_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [4:0]  amount;
  logic [31:0] operand;
  logic        ready;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic [31:0] sh_in;
  logic [2:0]  sh_code;
  logic [31:0] sh_out;
  logic [1:0]  dbg_state;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_q[$];
  logic [31:0] sb_exp;

  // ---------------------------------------------------------------- clock
  always #5 clk = ~clk;

  // ---------------------------------------------------------------- DUT
  shift_sequencer dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .op        (op),
    .amount    (amount),
    .operand   (operand),
    .ready     (ready),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .sh_in     (sh_in),
    .sh_code   (sh_code),
    .sh_out    (sh_out),
    .dbg_state (dbg_state)
  );

  // Single-step shifter model that the sequencer drives.
  always_comb begin
    case (sh_code)
      3'b001:  sh_out = {sh_in[30:0], 1'b0};
      3'b010:  sh_out = {1'b0, sh_in[31:1]};
      3'b011:  sh_out = {sh_in[31], sh_in[31:1]};
      3'b101:  sh_out = {sh_in[0], sh_in[31:1]};
      default: sh_out = sh_in;
    endcase
  end

  // Reference multi-bit shift, computed directly from the request.
  function automatic logic [31:0] ref_shift(input logic [31:0] x, input logic [1:0] o,
                                            input logic [4:0] a);
    logic signed [31:0] s;
    s = x;
    case (o)
      2'b00:   return x << a;
      2'b01:   return x >> a;
      2'b10:   return s >>> a;
      default: return (a == 5'd0) ? x : ((x >> a) | (x << (6'd32 - {1'b0, a})));
    endcase
  endfunction

  function automatic logic [2:0] code_of(input logic [1:0] o);
    case (o)
      2'b00:   return 3'b001;
      2'b01:   return 3'b010;
      2'b10:   return 3'b011;
      default: return 3'b101;
    endcase
  endfunction

  // ---------------------------------------------------------------- scoreboard
  always @(negedge clk) begin
    if (!reset && done) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL sb_unexpected_done: result=%h, no expected entry", result);
      end else begin
        sb_exp = exp_q.pop_front();
        if (result !== sb_exp) begin
          n_fail++;
          $display("FAIL sb_result: got %h expected %h", result, sb_exp);
        end
      end
    end
  end

  // ---------------------------------------------------------------- tests
  task automatic test_reset();
    reset = 1'b1; start = 1'b0; op = 2'd0; amount = 5'd0; operand = 32'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++;
      if ({ready, busy, done} !== 3'b100) begin
        n_fail++;
        $display("FAIL reset_flags[%0d]: ready/busy/done=%b expected 100", i, {ready, busy, done});
      end
      n_checks++;
      if (result !== 32'd0) begin
        n_fail++;
        $display("FAIL reset_result[%0d]: got %h expected 00000000", i, result);
      end
      n_checks++;
      if (sh_code !== 3'b000 || sh_in !== 32'd0) begin
        n_fail++;
        $display("FAIL reset_shifter[%0d]: sh_code=%b sh_in=%h expected 000/00000000", i, sh_code, sh_in);
      end
      n_checks++;
      if (dbg_state !== 2'd0) begin
        n_fail++;
        $display("FAIL reset_state[%0d]: got %0d expected 0", i, dbg_state);
      end
    end
  endtask

  task automatic test_directed();
    logic [31:0] c_opd [0:8];
    logic [1:0]  c_op  [0:8];
    logic [4:0]  c_amt [0:8];
    logic [31:0] c_exp [0:8];
    c_opd = '{32'h0000000F, 32'hF0000000, 32'hF0000000, 32'h0000000F, 32'hA5A50F0F,
              32'h00000001, 32'h80000001, 32'h80000000, 32'h12345678};
    c_op  = '{2'd0, 2'd2, 2'd1, 2'd3, 2'd2, 2'd0, 2'd3, 2'd2, 2'd3};
    c_amt = '{5'd4, 5'd3, 5'd3, 5'd4, 5'd0, 5'd31, 5'd0, 5'd31, 5'd31};
    c_exp = '{32'h000000F0, 32'hFE000000, 32'h1E000000, 32'hF0000000, 32'hA5A50F0F,
              32'h80000000, 32'h80000001, 32'hFFFFFFFF, 32'h2468ACF0};
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      n_checks++;
      if (ready !== 1'b1) begin
        n_fail++;
        $display("FAIL dir_ready[%0d]: got %b expected 1", i, ready);
      end
      operand = c_opd[i]; op = c_op[i]; amount = c_amt[i]; start = 1'b1;
      exp_q.push_back(ref_shift(c_opd[i], c_op[i], c_amt[i]));
      @(negedge clk);
      // Mid-operation input changes must have no effect.
      start = 1'b0; operand = $urandom(); op = 2'($urandom_range(0, 3));
      amount = 5'($urandom_range(0, 31));
      for (int k = 1; k <= int'(c_amt[i]) + 1; k++) begin
        if (k > 1) @(negedge clk);
        if (k <= int'(c_amt[i])) begin
          n_checks++;
          if ({busy, done, sh_code} !== {1'b1, 1'b0, code_of(c_op[i])}) begin
            n_fail++;
            $display("FAIL dir_shift[%0d] cyc %0d: busy/done/code=%b expected %b",
                     i, k, {busy, done, sh_code}, {1'b1, 1'b0, code_of(c_op[i])});
          end
        end else begin
          n_checks++;
          if (done !== 1'b1 || sh_code !== 3'b000) begin
            n_fail++;
            $display("FAIL dir_done[%0d] cyc %0d: done=%b sh_code=%b expected 1/000", i, k, done, sh_code);
          end
          n_checks++;
          if (result !== c_exp[i] || sh_in !== c_exp[i]) begin
            n_fail++;
            $display("FAIL dir_result[%0d]: result=%h sh_in=%h expected %h", i, result, sh_in, c_exp[i]);
          end
        end
      end
    end
  endtask

  task automatic test_ignore_start();
    int n_done = 0;
    int done_k = 0;
    @(negedge clk);
    operand = 32'h00000003; op = 2'd0; amount = 5'd8; start = 1'b1;
    exp_q.push_back(32'h00000300);
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (k == 1) start = 1'b0;
      if (k == 2) begin
        start = 1'b1; operand = 32'h0000FFFF; op = 2'd1; amount = 5'd1;
      end
      if (k == 4) start = 1'b0;
      if (done === 1'b1) begin
        n_done++;
        done_k = k;
        n_checks++;
        if (result !== 32'h00000300) begin
          n_fail++;
          $display("FAIL ign_result: got %h expected 00000300", result);
        end
      end
    end
    n_checks++;
    if (n_done != 1 || done_k != 9) begin
      n_fail++;
      $display("FAIL ign_done: %0d pulses, last at T+%0d, expected 1 pulse at T+9", n_done, done_k);
    end
  endtask

  task automatic test_reset_abort();
    int n_done = 0;
    @(negedge clk);
    operand = 32'h00000001; op = 2'd0; amount = 5'd31; start = 1'b1;
    exp_q.push_back(32'h80000000);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    exp_q.delete();
    @(negedge clk);
    n_checks++;
    if ({ready, busy, done} !== 3'b100 || result !== 32'd0) begin
      n_fail++;
      $display("FAIL abort_state: ready/busy/done=%b result=%h expected 100/00000000",
               {ready, busy, done}, result);
    end
    reset = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done === 1'b1) n_done++;
    end
    n_checks++;
    if (n_done != 0) begin
      n_fail++;
      $display("FAIL abort_no_done: got %0d pulses expected 0", n_done);
    end
    operand = 32'h00000001; op = 2'd0; amount = 5'd1; start = 1'b1;
    exp_q.push_back(32'h00000002);
    @(negedge clk);
    start = 1'b0;
    n_checks++;
    if (busy !== 1'b1 || sh_code !== 3'b001) begin
      n_fail++;
      $display("FAIL abort_next_shift: busy=%b sh_code=%b expected 1/001", busy, sh_code);
    end
    @(negedge clk);
    n_checks++;
    if (done !== 1'b1 || result !== 32'h00000002) begin
      n_fail++;
      $display("FAIL abort_next_done: done=%b result=%h expected 1/00000002", done, result);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] r_opd;
    logic [1:0]  r_op;
    logic [4:0]  r_amt;
    int          k;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      n_checks++;
      if (ready !== 1'b1) begin
        n_fail++;
        $display("FAIL b2b_ready[%0d]: got %b expected 1", i, ready);
      end
      r_opd = $urandom(); r_op = 2'($urandom_range(0, 3)); r_amt = 5'($urandom_range(0, 31));
      operand = r_opd; op = r_op; amount = r_amt; start = 1'b1;
      exp_q.push_back(ref_shift(r_opd, r_op, r_amt));
      k = 0;
      do begin
        @(negedge clk);
        start = 1'b0;
        k++;
      end while (done !== 1'b1 && k < 40);
      n_checks++;
      if (done !== 1'b1 || k != int'(r_amt) + 1) begin
        n_fail++;
        $display("FAIL b2b_latency[%0d]: done=%b after %0d cycles expected at %0d",
                 i, done, k, int'(r_amt) + 1);
      end
    end
  endtask

  // ---------------------------------------------------------------- main
  initial begin
    test_reset();
    test_directed();
    test_ignore_start();
    test_reset_abort();
    test_back_to_back();
    repeat (2) @(negedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL sb_leftover: %0d expected results never produced, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/shift_sequencer.md
Name: shift_sequencer

Overview:
- Multi-cycle controller that sequences the shared single-step 32-bit shifter to perform shifts of 0..31 positions.
- Accepts one request: operand, operation and amount. Drives the shifter's code and input once per cycle, feeding its output back for `amount` cycles.
- Returns the result with a one-cycle done pulse.
- Sits between the execute-stage control and the shifter instance. The shifter itself stays purely combinational.

Parameters:
- CODE_PASS, 3'b000, shifter code for pass-through (no shift)
- CODE_SLL, 3'b001, shifter code for logical left by 1
- CODE_SRL, 3'b010, shifter code for logical right by 1
- CODE_SRA, 3'b011, shifter code for arithmetic right by 1
- CODE_ROR, 3'b101, shifter code for rotate right by 1

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- start  in  1  request strobe; sampled only when ready=1
- op  in  2  operation: 00 SLL, 01 SRL, 10 SRA, 11 ROR
- amount  in  5  shift distance, 0..31
- operand  in  32  value to shift
- ready  out  1  high in IDLE only; request accepted when start=1 and ready=1
- busy  out  1  high in SHIFT and DONE
- done  out  1  one-cycle pulse, result valid
- result  out  32  registered result; holds until the next done
- sh_in  out  32  to shifter `in`
- sh_code  out  3  to shifter `sh`
- sh_out  in  32  from shifter `out` (combinational path, same cycle)

Behaviour:
- Registers: state (IDLE/SHIFT/DONE), acc[31:0], cnt[4:0], op_q[1:0], result[31:0].
- Reset (clk edge with reset=1), overriding all else:
  - state=IDLE, acc=0, cnt=0, op_q=0, result=0.
  - Outputs: done=0, ready=1, busy=0, sh_code=CODE_PASS, sh_in=0.
- sh_in = acc at all times.
- sh_code is combinational from state:
  - In SHIFT: the code selected by op_q.
  - Otherwise: CODE_PASS.
- IDLE:
  - On start=1: acc<=operand, op_q<=op, cnt<=amount.
  - amount==0 → DONE; otherwise → SHIFT.
  - start=0: stay in IDLE.
- SHIFT:
  - Each cycle: acc<=sh_out, cnt<=cnt-1.
  - When cnt==1 this cycle, next state is DONE.
  - Exactly `amount` shifter steps are applied; cnt never wraps below 0.
- DONE:
  - done=1, result<=acc (visible from the same edge that leaves DONE is NOT acceptable).
  - result is written when entering DONE, so done and the new result are coincident.
  - Next state is always IDLE.
- Timing: start sampled at edge T.
  - done is high during cycle T+amount+1, i.e. T+1 for amount=0 and T+32 for amount=31.
  - Back-to-back issue: the next start is accepted at the edge after the DONE cycle.
- start, op, amount and operand are ignored while busy=1; no queuing.
- Request inputs are only captured at acceptance, so changes mid-operation have no effect.
- Reset mid-operation aborts the operation: no done pulse and result cleared to 0.
- sh_out is ignored in IDLE and DONE.
- Shift semantics are defined by the shifter. This block guarantees the step count and code sequence only.

Test Plan:
- Reset, then hold reset=0 with start=0 for 3 cycles → ready=1, busy=0, done=0, result=0x00000000, sh_code=000 throughout.
- operand=0x0000000F, op=SLL, amount=4, start at T:
  - sh_code=001 for cycles T+1..T+4.
  - done=1 at T+5 with result=0x000000F0, then ready=1 at T+6.
- operand=0xF0000000:
  - op=SRA, amount=3 → result=0xFE000000 at T+4.
  - Repeat with op=SRL → result=0x1E000000.
- Boundary amounts:
  - op=ROR, operand=0x0000000F, amount=4 → result=0xF0000000.
  - amount=0 (any op) → done at T+1, result=operand, sh_code never leaves 000.
  - operand=0x00000001, SLL, amount=31 → done at T+32, result=0x80000000.
- Start, op and amount=8 accepted at T; second start with different operand at T+2 → ignored; single done at T+9 with first operand's result.
- Reset asserted at T+3 of an amount=31 shift:
  - IDLE at T+4 with ready=1, result=0.
  - No done pulse within the following 40 cycles.
  - A new amount=1 SLL on 0x1 completes with result=0x00000002.
